led_tick_counter: RTL and testbench
===================================

// Module: led_tick_counter
//
// PURPOSE
//   Parametrised tick-rate counter that drives the LEDs. A prescaler divides
//   clk down to a single-cycle tick enable, so all logic stays in the clk
//   domain and no derived clock is generated. On each tick the counter steps
//   up or down, and either wraps or saturates at its bounds. Sits between the
//   board oscillator/button inputs and the LED pins.
//
// PARAMETERS
//   CLK_HZ     12000000       input clock frequency, Hz
//   TICK_HZ    1              count rate, Hz; DIV = CLK_HZ/TICK_HZ, DIV >= 1
//   WIDTH      4              counter / LED width, bits (1..16)
//   MAX_COUNT  2**WIDTH-1     upper bound of the count (1..2**WIDTH-1)
//   SATURATE   0              0: wrap at bounds; 1: hold at bounds
//
// PORTS
//   clk       in   1      system clock
//   rst       in   1      asynchronous reset, active-high
//   run       in   1      1: prescaler and counter advance; 0: both frozen
//   dir       in   1      1: count up; 0: count down (sampled on tick edge)
//   load      in   1      synchronous load strobe
//   load_val  in   WIDTH  value to load
//   tick      out  1      one-cycle pulse, coincident with each count update
//   wrap      out  1      one-cycle pulse when the count wraps
//   count     out  WIDTH  current binary count
//   led       out  WIDTH  LED drive pattern
//
// BEHAVIOUR
//   - Reset: prescaler=0, count=0, led=0, tick=0, wrap=0. All outputs are
//     registered.
//   - Prescaler width is $clog2(DIV), minimum 1 bit. It counts 0..DIV-1.
//     On the edge where run=1 and prescaler==DIV-1: prescaler<=0, tick<=1,
//     and count<=next. With DIV==1, tick is high on every run cycle.
//   - Result: tick is high for exactly the one cycle in which count shows
//     the new value. The tick period is DIV clk cycles while run=1.
//   - run=0: prescaler, count and led hold; tick<=0; wrap<=0. When run
//     returns to 1, the prescaler resumes from its held value.
//   - Priority: load > tick. On load=1 (regardless of run):
//       count <= min(load_val, MAX_COUNT); prescaler <= 0;
//       tick <= 0; wrap <= 0.
//     A tick that would fall on that edge is discarded.
//   - Next value, dir=1: count<MAX_COUNT -> count+1.
//       At MAX_COUNT: SATURATE=0 -> 0 with wrap=1; SATURATE=1 -> hold, wrap=0.
//   - Next value, dir=0: count>0 -> count-1.
//       At 0: SATURATE=0 -> MAX_COUNT with wrap=1; SATURATE=1 -> hold, wrap=0.
//   - wrap is high only in the tick cycle in which the wrap occurs.
//   - led is registered from the next count value, so it changes on the
//     same edge as count.
//   - rst asserted mid-count returns everything to reset values at once.
//     The first tick after rst deasserts follows DIV run cycles later.
//
// CONFIGURATION
//   COUNTER_GRAY_EN defined:   led <= next ^ (next >> 1), i.e. Gray code;
//                              adjacent counts differ in exactly one LED.
//   COUNTER_GRAY_EN undefined: led <= next, i.e. plain binary; led == count.
//   count, tick and wrap are identical in both builds.
//
// TESTING  (CLK_HZ=8, TICK_HZ=2 -> DIV=4; WIDTH=4; MAX_COUNT=15 unless noted)
//   1. rst pulse, then run=1, dir=1 -> tick every 4th clk; count 0,1,2,...
//      15,0. wrap=1 only on the 15->0 tick.
//   2. dir=0 from count=0 -> count 15 with wrap=1; then 14, 13, ...
//      Repeat with SATURATE=1 -> count holds at 0, wrap never asserts.
//   3. MAX_COUNT=9, dir=1 -> 8, 9, 0 with wrap. load_val=12 -> count=9.
//   4. load=1, load_val=5, asserted on the cycle a tick is due -> count=5,
//      tick=0. Next tick occurs 4 clks later, with count=6.
//   5. run=0 for 10 clks mid-period -> count, led frozen, no tick.
//      run=1 -> tick resumes after the remaining prescaler cycles.
//   6. COUNTER_GRAY_EN build: counts 0..15 -> led 0,1,3,2,6,... with a
//      one-bit change per tick. Assert rst mid-period -> all outputs 0
//      asynchronously.

Source files
------------

// File: rtl/led_tick_counter.sv
// led_tick_counter: prescaled up/down counter driving the board LEDs.
// A prescaler turns clk into a one-cycle tick enable. On each tick the count
// steps up or down, and either wraps or saturates at its bounds.
// Optional build macro COUNTER_GRAY_EN: led shows the Gray code of the count
// instead of the plain binary value.
module led_tick_counter #(
    parameter int CLK_HZ    = 12000000,
    parameter int TICK_HZ   = 1,
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int SATURATE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tick,
    output logic             wrap,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] led
);

    localparam int               DIV        = CLK_HZ / TICK_HZ;
    localparam int               PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MAX_COUNT);

    logic [PW-1:0]    prescaler;
    logic [WIDTH-1:0] next_count;
    logic             next_wrap;
    logic [WIDTH-1:0] load_count;
    logic             tick_due;

    // LED pattern for a given count: Gray code in the Gray build, binary otherwise.
    function automatic logic [WIDTH-1:0] led_code(input logic [WIDTH-1:0] v);
`ifdef COUNTER_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    // Value the count moves to on a tick, and whether that step is a wrap.
    always_comb begin
        next_count = count;
        next_wrap  = 1'b0;
        if (dir) begin
            if (count < MAX_VAL) begin
                next_count = count + 1'b1;
            end else if (SATURATE == 0) begin
                next_count = '0;
                next_wrap  = 1'b1;
            end
        end else begin
            if (count != '0) begin
                next_count = count - 1'b1;
            end else if (SATURATE == 0) begin
                next_count = MAX_VAL;
                next_wrap  = 1'b1;
            end
        end
    end

    // Clamp the loaded value to the upper bound and detect the last prescaler cycle.
    always_comb begin
        load_count = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        tick_due   = run && (prescaler == PRESC_LAST);
    end

    // Prescaler, count and registered outputs; a load overrides any tick due on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            count     <= '0;
            led       <= '0;
            tick      <= 1'b0;
            wrap      <= 1'b0;
        end else if (load) begin
            prescaler <= '0;
            count     <= load_count;
            led       <= led_code(load_count);
            tick      <= 1'b0;
            wrap      <= 1'b0;
        end else if (tick_due) begin
            prescaler <= '0;
            count     <= next_count;
            led       <= led_code(next_count);
            tick      <= 1'b1;
            wrap      <= next_wrap;
        end else if (run) begin
            prescaler <= prescaler + 1'b1;
            tick      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            tick      <= 1'b0;
            wrap      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_tick_counter.sv
// Testbench for led_tick_counter: three instances (wrap at 15, saturate at 9,
// wrap at 9) share one stimulus stream; a reference model pushes expected
// outputs into per-instance queues and a monitor pops and compares each cycle.
// Honours COUNTER_GRAY_EN in the same way as the design.
module tb_led_tick_counter;

    localparam int DIV = 4;
    localparam int N   = 3;

    typedef struct packed {
        logic       tick;
        logic       wrap;
        logic [3:0] count;
        logic [3:0] led;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;

    logic       tick_a, wrap_a, tick_b, wrap_b, tick_c, wrap_c;
    logic [3:0] count_a, led_a, count_b, led_b, count_c, led_c;

    int checks = 0;
    int errors = 0;

    obs_t exp_q [N][$];

    int max_v [N] = '{15, 9, 9};
    int sat_v [N] = '{0, 1, 0};
    int m_count [N];
    int m_phase;

    led_tick_counter #(.CLK_HZ(8), .TICK_HZ(2), .WIDTH(4), .MAX_COUNT(15), .SATURATE(0)) u_a (
        .clk(clk), .rst(rst), .run(run), .dir(dir), .load(load), .load_val(load_val),
        .tick(tick_a), .wrap(wrap_a), .count(count_a), .led(led_a));

    led_tick_counter #(.CLK_HZ(8), .TICK_HZ(2), .WIDTH(4), .MAX_COUNT(9), .SATURATE(1)) u_b (
        .clk(clk), .rst(rst), .run(run), .dir(dir), .load(load), .load_val(load_val),
        .tick(tick_b), .wrap(wrap_b), .count(count_b), .led(led_b));

    led_tick_counter #(.CLK_HZ(8), .TICK_HZ(2), .WIDTH(4), .MAX_COUNT(9), .SATURATE(0)) u_c (
        .clk(clk), .rst(rst), .run(run), .dir(dir), .load(load), .load_val(load_val),
        .tick(tick_c), .wrap(wrap_c), .count(count_c), .led(led_c));

    always #5 clk = ~clk;

    function automatic logic [3:0] ledOf(input int v);
        logic [3:0] b;
        b = v[3:0];
`ifdef COUNTER_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    function automatic obs_t actualOf(input int idx);
        obs_t o;
        case (idx)
            0:       o = '{tick_a, wrap_a, count_a, led_a};
            1:       o = '{tick_b, wrap_b, count_b, led_b};
            default: o = '{tick_c, wrap_c, count_c, led_c};
        endcase
        return o;
    endfunction

    task automatic checkOutput(input string name, input int idx, input obs_t e);
        obs_t a;
        a = actualOf(idx);
        checks++;
        if (a !== e) begin
            errors++;
            $display("[TB] FAIL %s dut%0d @%0t: got tick=%b wrap=%b count=%0d led=%h, expected tick=%b wrap=%b count=%0d led=%h",
                     name, idx, $time, a.tick, a.wrap, a.count, a.led, e.tick, e.wrap, e.count, e.led);
        end
    endtask

    // Drive one cycle of inputs and push the model's view of the outputs after the next edge.
    task automatic applyStimulus(input logic r, input logic d, input logic l, input int lv);
        logic t;
        logic w [N];
        @(negedge clk);
        run = r; dir = d; load = l; load_val = lv[3:0];
        t = 1'b0;
        for (int i = 0; i < N; i++) w[i] = 1'b0;
        if (l) begin
            m_phase = 0;
            for (int i = 0; i < N; i++) m_count[i] = (lv > max_v[i]) ? max_v[i] : lv;
        end else if (r) begin
            m_phase++;
            if (m_phase == DIV) begin
                m_phase = 0;
                t = 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (d) begin
                        if (m_count[i] < max_v[i]) m_count[i]++;
                        else if (sat_v[i] == 0) begin m_count[i] = 0; w[i] = 1'b1; end
                    end else begin
                        if (m_count[i] > 0) m_count[i]--;
                        else if (sat_v[i] == 0) begin m_count[i] = max_v[i]; w[i] = 1'b1; end
                    end
                end
            end
        end
        for (int i = 0; i < N; i++)
            exp_q[i].push_back('{t, w[i], m_count[i][3:0], ledOf(m_count[i])});
    endtask

    // Assert reset between edges and check that every output clears before any clock edge.
    task automatic resetMid();
        obs_t z;
        z = '0;
        @(negedge clk);
        #2 rst = 1'b1; run = 1'b0; load = 1'b0;
        #1;
        for (int i = 0; i < N; i++) checkOutput("async_reset", i, z);
        m_phase = 0;
        for (int i = 0; i < N; i++) m_count[i] = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare the DUT against the oldest expected entry after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++)
                if (exp_q[i].size() > 0) checkOutput("cycle", i, exp_q[i].pop_front());
        end
    end

    initial begin
        obs_t z;
        int guard;
        z = '0;
        m_phase = 0;
        for (int i = 0; i < N; i++) m_count[i] = 0;

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) checkOutput("reset_state", i, z);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] counting up through the wrap");
        for (int k = 0; k < 70; k++) applyStimulus(1'b1, 1'b1, 1'b0, 0);

        $display("[TB] counting down from zero");
        resetMid();
        for (int k = 0; k < 24; k++) applyStimulus(1'b1, 1'b0, 1'b0, 0);

        $display("[TB] load coinciding with a due tick, then clamped load");
        guard = 0;
        while (m_phase != DIV - 1 && guard < 10) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 0);
            guard++;
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 5);
        for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b1, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 12);
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b1, 1'b0, 0);

        $display("[TB] freezing mid-period");
        applyStimulus(1'b1, 1'b1, 1'b0, 0);
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b1, 1'b0, 0);
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b1, 1'b0, 0);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 800; k++) begin
            applyStimulus(($urandom % 8) != 0, ($urandom % 3) != 0,
                          ($urandom % 25) == 0, int'($urandom % 16));
            if (k == 400) resetMid();
        end

        guard = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        checks++;
        if ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0",
                     exp_q[0].size() + exp_q[1].size() + exp_q[2].size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
